// File: rtl/rvh_ptw_mem_responder.sv
// Page-table-walk responder: turns one MMU walk request into one
// beat-aligned memory read and returns the selected 64-bit PTE.
//
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   ptw_walk_req_*             walk request from MMU (vld/id/addr/rdy)
//   ptw_walk_resp_*            PTE response to MMU (vld/pte/rdy)
//   mem_req_*                  memory read request (vld/id/addr/rdy)
//   mem_resp_*                 memory read data (vld/data/rdy)
//   busy_o                     a walk is in flight
//   timeout_o                  sticky timeout flag (PTW_TIMEOUT_EN only)
//
// Optional feature macro: PTW_TIMEOUT_EN bounds the MEM_WAIT state to
// TIMEOUT_CYCLES cycles and answers with an all-zero (invalid) PTE.

module rvh_ptw_mem_responder #(
  parameter int PTW_ID_WIDTH   = 1,
  parameter int PADDR_WIDTH    = 56,
  parameter int MEM_DATA_WIDTH = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      ptw_walk_req_vld_i,
  input  logic [PTW_ID_WIDTH-1:0]   ptw_walk_req_id_i,
  input  logic [PADDR_WIDTH-1:0]    ptw_walk_req_addr_i,
  output logic                      ptw_walk_req_rdy_o,
  output logic                      ptw_walk_resp_vld_o,
  output logic [63:0]               ptw_walk_resp_pte_o,
  input  logic                      ptw_walk_resp_rdy_i,
  output logic                      mem_req_vld_o,
  output logic [PTW_ID_WIDTH-1:0]   mem_req_id_o,
  output logic [PADDR_WIDTH-1:0]    mem_req_addr_o,
  input  logic                      mem_req_rdy_i,
  input  logic                      mem_resp_vld_i,
  input  logic [MEM_DATA_WIDTH-1:0] mem_resp_data_i,
  output logic                      mem_resp_rdy_o,
  output logic                      busy_o
`ifdef PTW_TIMEOUT_EN
  ,
  output logic                      timeout_o
`endif
);

  localparam int NDW   = MEM_DATA_WIDTH / 64;
  localparam int SEL_W = (NDW > 1) ? $clog2(NDW) : 1;

  localparam logic [PADDR_WIDTH-1:0] ADDR_MASK =
    ~PADDR_WIDTH'(MEM_DATA_WIDTH / 8 - 1);

  if (MEM_DATA_WIDTH < 64 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("rvh_ptw_mem_responder: bad parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    MEM_REQ,
    MEM_WAIT,
    RESP
  } state_t;

  state_t                  state;
  logic [PADDR_WIDTH-1:0]  addr_q;
  logic [PTW_ID_WIDTH-1:0] id_q;
  logic [63:0]             pte_q;

  // beat viewed as an array of dwords; sel picks the one holding the PTE
  logic [NDW-1:0][63:0] beat;
  logic [SEL_W-1:0]     sel;

  assign beat = mem_resp_data_i;

  if (NDW > 1) begin : g_sel
    assign sel = addr_q[SEL_W+2:3];
  end else begin : g_nosel
    assign sel = '0;
  end

`ifdef PTW_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;

  assign timeout_o = timeout_q;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      addr_q <= '0;
      id_q   <= '0;
      pte_q  <= '0;
`ifdef PTW_TIMEOUT_EN
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (ptw_walk_req_vld_i) begin
            addr_q <= ptw_walk_req_addr_i;
            id_q   <= ptw_walk_req_id_i;
            state  <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (mem_req_rdy_i) begin
            state <= MEM_WAIT;
`ifdef PTW_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        MEM_WAIT: begin
          if (mem_resp_vld_i) begin
            pte_q <= beat[sel];
            state <= RESP;
          end
`ifdef PTW_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + 1'b1;
            // counter reaches TIMEOUT_CYCLES on this edge
            if (wait_cnt == CNT_LAST) begin
              pte_q     <= '0;
              timeout_q <= 1'b1;
              state     <= RESP;
            end
          end
`endif
        end
        RESP: begin
          if (ptw_walk_resp_rdy_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // all handshake outputs are pure decodes of the state register
  assign ptw_walk_req_rdy_o  = (state == IDLE);
  assign mem_req_vld_o       = (state == MEM_REQ);
  assign mem_resp_rdy_o      = (state == MEM_WAIT);
  assign ptw_walk_resp_vld_o = (state == RESP);
  assign busy_o              = (state != IDLE);

  assign ptw_walk_resp_pte_o = pte_q;
  assign mem_req_id_o        = id_q;
  assign mem_req_addr_o      = addr_q & ADDR_MASK;

endmodule

// File: tb/tb_rvh_ptw_mem_responder.sv
// Bench for rvh_ptw_mem_responder: transaction-level model plus
// directed walks with hand-computed PTE, address and latency values.

`timescale 1ns/1ps

module tb_rvh_ptw_mem_responder;

  logic         clk = 1'b0;
  logic         rstn;
  logic         req_vld;
  logic [0:0]   req_id;
  logic [55:0]  req_addr;
  logic         resp_rdy;
  logic         mem_req_rdy;
  logic         mem_resp_vld;
  logic [127:0] mem_resp_data;

  logic         ptw_walk_req_rdy_o;
  logic         ptw_walk_resp_vld_o;
  logic [63:0]  ptw_walk_resp_pte_o;
  logic         mem_req_vld_o;
  logic [0:0]   mem_req_id_o;
  logic [55:0]  mem_req_addr_o;
  logic         mem_resp_rdy_o;
  logic         busy_o;
`ifdef PTW_TIMEOUT_EN
  logic         timeout_o;
`endif

  int vecs = 0;
  int miscompares = 0;
  int cyc_n = 0;

  rvh_ptw_mem_responder #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .ptw_walk_req_vld_i  (req_vld),
    .ptw_walk_req_id_i   (req_id),
    .ptw_walk_req_addr_i (req_addr),
    .ptw_walk_req_rdy_o  (ptw_walk_req_rdy_o),
    .ptw_walk_resp_vld_o (ptw_walk_resp_vld_o),
    .ptw_walk_resp_pte_o (ptw_walk_resp_pte_o),
    .ptw_walk_resp_rdy_i (resp_rdy),
    .mem_req_vld_o       (mem_req_vld_o),
    .mem_req_id_o        (mem_req_id_o),
    .mem_req_addr_o      (mem_req_addr_o),
    .mem_req_rdy_i       (mem_req_rdy),
    .mem_resp_vld_i      (mem_resp_vld),
    .mem_resp_data_i     (mem_resp_data),
    .mem_resp_rdy_o      (mem_resp_rdy_o),
    .busy_o              (busy_o)
`ifdef PTW_TIMEOUT_EN
    ,
    .timeout_o           (timeout_o)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Model: one walk record with milestones, updated from the
  // handshakes that happen on each rising edge.
  bit          m_live = 0;
  bit          m_active;
  bit          m_issued;
  bit          m_got;
  logic [55:0] m_addr;
  logic [0:0]  m_id;
  logic [63:0] m_pte;
  int          m_wait;
  bit          m_tmo;

  always @(posedge clk) begin
    if (!rstn) begin
      m_live   = 1;
      m_active = 0;
      m_pte    = '0;
      m_tmo    = 0;
    end else if (!m_active) begin
      if (req_vld) begin
        m_active = 1;
        m_issued = 0;
        m_got    = 0;
        m_addr   = req_addr;
        m_id     = req_id;
      end
    end else if (!m_issued) begin
      if (mem_req_rdy) begin
        m_issued = 1;
        m_wait   = 0;
      end
    end else if (!m_got) begin
      if (mem_resp_vld) begin
        m_got = 1;
        m_pte = 64'(mem_resp_data >> (64 * int'(m_addr[3])));
      end else begin
        m_wait++;
`ifdef PTW_TIMEOUT_EN
        if (m_wait == 8) begin
          m_got = 1;
          m_pte = '0;
          m_tmo = 1;
        end
`endif
      end
    end else if (resp_rdy) begin
      m_active = 0;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("req_rdy", 64'(ptw_walk_req_rdy_o), 64'(!m_active));
      chk("busy", 64'(busy_o), 64'(m_active));
      chk("mem_req_vld", 64'(mem_req_vld_o),
          64'(m_active && !m_issued));
      if (m_active && !m_issued) begin
        chk("mem_req_addr", 64'(mem_req_addr_o),
            64'((m_addr >> 4) << 4));
        chk("mem_req_id", 64'(mem_req_id_o), 64'(m_id));
      end
      chk("mem_resp_rdy", 64'(mem_resp_rdy_o),
          64'(m_active && m_issued && !m_got));
      chk("resp_vld", 64'(ptw_walk_resp_vld_o),
          64'(m_active && m_got));
      chk("resp_pte", ptw_walk_resp_pte_o, m_pte);
`ifdef PTW_TIMEOUT_EN
      chk("timeout", 64'(timeout_o), 64'(m_tmo));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [55:0] a,
                           input logic [0:0] id,
                           output int acc);
    int t;
    req_addr = a;
    req_id   = id;
    req_vld  = 1;
    t = 0;
    while (!ptw_walk_req_rdy_o && t < 50) begin
      cyc();
      t++;
    end
    if (t >= 50) chk("req_accept_bound", 64'd0, 64'd1);
    acc = cyc_n;
    cyc();
    req_vld = 0;
  endtask

  task automatic mem_phase(input int mdly, input logic [127:0] d);
    repeat (mdly) cyc();
    mem_req_rdy = 1;
    cyc();
    mem_req_rdy  = 0;
    mem_resp_vld = 1;
    mem_resp_data = d;
    cyc();
    mem_resp_vld  = 0;
    mem_resp_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic resp_phase(input int rdly, output int hs);
    repeat (rdly) cyc();
    resp_rdy = 1;
    hs = cyc_n;
    cyc();
    resp_rdy = 0;
  endtask

  localparam logic [127:0] D0 =
    {64'h0000_0000_DEAD_0001, 64'h0000_0000_2000_00CF};
  localparam logic [127:0] D1 =
    {64'h1111_AAAA_0000_0001, 64'h2222_BBBB_0000_0001};
  localparam logic [127:0] D2 =
    {64'h3333_DDDD_0000_0001, 64'h4444_CCCC_0000_00C1};
  localparam logic [127:0] D3 =
    {64'h0BAD_F00D_0000_0007, 64'h5555_0000_0000_0001};

  initial begin
    int acc, acc2, hs, lat;
    rstn = 0;
    req_vld = 0;
    req_id = '0;
    req_addr = '0;
    resp_rdy = 0;
    mem_req_rdy = 0;
    mem_resp_vld = 0;
    mem_resp_data = '0;
    repeat (2) cyc();
    rstn = 1;

    chk("rst_req_rdy", 64'(ptw_walk_req_rdy_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_mem_req_vld", 64'(mem_req_vld_o), 64'd0);
    chk("rst_pte", ptw_walk_resp_pte_o, 64'd0);
`ifdef PTW_TIMEOUT_EN
    chk("rst_timeout", 64'(timeout_o), 64'd0);
`endif
    cyc();

    // basic walk, upper dword
    start_req(56'h80001008, 1'b0, acc);
    chk("basic_mem_addr", 64'(mem_req_addr_o), 64'h80001000);
    mem_phase(0, D0);
    lat = cyc_n - acc;
    chk("basic_latency", 64'(lat), 64'd3);
    chk("basic_resp_vld", 64'(ptw_walk_resp_vld_o), 64'd1);
    chk("basic_pte", ptw_walk_resp_pte_o, 64'hDEAD_0001);
    resp_phase(0, hs);
    chk("basic_busy_after", 64'(busy_o), 64'd0);
    cyc();

    // low dword select, id=1
    start_req(56'h80001000, 1'b1, acc);
    chk("low_mem_id", 64'(mem_req_id_o), 64'd1);
    mem_phase(0, D0);
    chk("low_pte", ptw_walk_resp_pte_o, 64'h2000_00CF);
    resp_phase(1, hs);
    cyc();

    // backpressure on both sides, low addr bits ignored
    start_req(56'hAB_CDEF_0123_450F, 1'b1, acc);
    chk("bp_mem_addr", 64'(mem_req_addr_o), 64'hAB_CDEF_0123_4500);
    mem_phase(5, D3);
    chk("bp_pte", ptw_walk_resp_pte_o, 64'h0BAD_F00D_0000_0007);
    resp_phase(4, hs);
    cyc();

    // back-to-back: second request held valid during RESP
    start_req(56'h80002008, 1'b0, acc);
    mem_phase(0, D1);
    chk("b2b_pte1", ptw_walk_resp_pte_o, 64'h1111_AAAA_0000_0001);
    req_addr = 56'h80003000;
    req_id = 1'b1;
    req_vld = 1;
    resp_phase(2, hs);
    start_req(56'h80003000, 1'b1, acc2);
    chk("b2b_accept_gap", 64'(acc2 - hs), 64'd1);
    mem_phase(1, D2);
    chk("b2b_pte2", ptw_walk_resp_pte_o, 64'h4444_CCCC_0000_00C1);
    resp_phase(0, hs);
    cyc();

    // reset while waiting for memory data
    start_req(56'h80004008, 1'b0, acc);
    mem_req_rdy = 1;
    cyc();
    mem_req_rdy = 0;
    chk("rstw_mem_resp_rdy", 64'(mem_resp_rdy_o), 64'd1);
    rstn = 0;
    cyc();
    rstn = 1;
    chk("rstw_req_rdy", 64'(ptw_walk_req_rdy_o), 64'd1);
    chk("rstw_busy", 64'(busy_o), 64'd0);
    chk("rstw_mem_resp_rdy0", 64'(mem_resp_rdy_o), 64'd0);
    chk("rstw_resp_vld", 64'(ptw_walk_resp_vld_o), 64'd0);
    chk("rstw_pte", ptw_walk_resp_pte_o, 64'd0);
    mem_resp_vld = 1;
    mem_resp_data = D0;
    cyc();
    mem_resp_vld = 0;
    chk("rstw_late_resp_vld", 64'(ptw_walk_resp_vld_o), 64'd0);
    chk("rstw_late_busy", 64'(busy_o), 64'd0);

    // walk after reset behaves normally
    start_req(56'h80005008, 1'b1, acc);
    mem_phase(0, D2);
    chk("post_rst_pte", ptw_walk_resp_pte_o, 64'h3333_DDDD_0000_0001);
    resp_phase(0, hs);
    cyc();

`ifdef PTW_TIMEOUT_EN
    start_req(56'h80006000, 1'b0, acc);
    mem_req_rdy = 1;
    cyc();
    mem_req_rdy = 0;
    repeat (7) cyc();
    chk("tmo_not_yet", 64'(ptw_walk_resp_vld_o), 64'd0);
    cyc();
    chk("tmo_resp_vld", 64'(ptw_walk_resp_vld_o), 64'd1);
    chk("tmo_pte", ptw_walk_resp_pte_o, 64'd0);
    chk("tmo_flag", 64'(timeout_o), 64'd1);
    mem_resp_vld = 1;
    mem_resp_data = D0;
    cyc();
    mem_resp_vld = 0;
    chk("tmo_late_pte", ptw_walk_resp_pte_o, 64'd0);
    resp_phase(0, hs);
    cyc();
    chk("tmo_sticky", 64'(timeout_o), 64'd1);
`endif

    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
